// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: single-transaction sequencer for an SRAM-like memory
// (ce/oe/we strobes, ready handshake). Exports its one-hot state and
// the last read word to the display layer.
//
// Optional build macro: MEM_SEQ_TIMEOUT_EN. When defined, the read and
// write wait states abort to IDLE after TIMEOUT_CYCLES cycles without
// mem_ready and pulse err. When undefined, the waits are unbounded and
// err is tied low.
//
// state      | meaning
// -----------+-------------------------------------------------------
// RESET      | memory power-up settle, RESET_CYCLES cycles
// IDLE       | waiting for rd_req / wr_req (read has priority)
// RD0        | read setup, ce only
// RD1        | ce + oe
// RD2        | ce + oe
// RD_WAIT    | ce + oe until mem_ready, rd_data captured on exit
// RD_DONE    | strobes released, hold until ack
// WR0        | ce + drv, data bus setup
// WR1        | ce + drv
// WR2        | ce + drv + we
// WR3        | ce + drv + we
// WR4        | ce + drv, we hold time
// WR_WAIT    | ce + drv until mem_ready

module mem_seq_ctrl #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int RESET_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic              ack,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_ce,
   output logic              mem_oe,
   output logic              mem_we,
   output logic              mem_drv,
   output logic [12:0]       state,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              err
);

   typedef enum logic [12:0] {
      ST_RESET   = 13'h0001,
      ST_IDLE    = 13'h0002,
      ST_RD0     = 13'h0004,
      ST_RD1     = 13'h0008,
      ST_RD2     = 13'h0010,
      ST_RD_WAIT = 13'h0020,
      ST_RD_DONE = 13'h0040,
      ST_WR0     = 13'h0080,
      ST_WR1     = 13'h0100,
      ST_WR2     = 13'h0200,
      ST_WR3     = 13'h0400,
      ST_WR4     = 13'h0800,
      ST_WR_WAIT = 13'h1000
   } state_t;

   localparam int RCW = $clog2(RESET_CYCLES + 1);

   if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mem_seq_ctrl: RESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
   end

   state_t           state_q;
   state_t           state_d;
   logic [RCW-1:0]   rst_cnt;
   logic             in_wait;
   logic             timeout_hit;
   logic             accept;

   assign in_wait = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
   assign accept  = (state_q == ST_IDLE) && (rd_req || wr_req);

   // settle timer: preloaded whenever outside RESET, runs down to terminal count inside it
   always_ff @(posedge clk) begin
      if (rst || state_q != ST_RESET)
         rst_cnt <= RCW'(RESET_CYCLES - 1);
      else if (rst_cnt != '0)
         rst_cnt <= rst_cnt - 1'b1;
   end

`ifdef MEM_SEQ_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TCW-1:0] wait_cnt;
   logic           err_q;

   // wait timer: reloaded outside the wait states, counts down on cycles without mem_ready
   always_ff @(posedge clk) begin
      if (rst || !in_wait)
         wait_cnt <= TCW'(TIMEOUT_CYCLES - 1);
      else if (!mem_ready && wait_cnt != '0)
         wait_cnt <= wait_cnt - 1'b1;
   end

   assign timeout_hit = in_wait && !mem_ready && (wait_cnt == '0);

   // one-cycle error pulse coinciding with the abort back to IDLE
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else
         err_q <= timeout_hit;
   end

   assign err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_RESET;
      else
         state_q <= state_d;
   end

   // next-state logic; any non-one-hot value falls back to RESET
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:   if (rst_cnt == '0) state_d = ST_IDLE;
         ST_IDLE: begin
            if (rd_req)      state_d = ST_RD0;
            else if (wr_req) state_d = ST_WR0;
         end
         ST_RD0:     state_d = ST_RD1;
         ST_RD1:     state_d = ST_RD2;
         ST_RD2:     state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (mem_ready)        state_d = ST_RD_DONE;
            else if (timeout_hit) state_d = ST_IDLE;
         end
         ST_RD_DONE: if (ack) state_d = ST_IDLE;
         ST_WR0:     state_d = ST_WR1;
         ST_WR1:     state_d = ST_WR2;
         ST_WR2:     state_d = ST_WR3;
         ST_WR3:     state_d = ST_WR4;
         ST_WR4:     state_d = ST_WR_WAIT;
         ST_WR_WAIT: if (mem_ready || timeout_hit) state_d = ST_IDLE;
         default:    state_d = ST_RESET;
      endcase
   end

   // address/data latched only on accept so they stay frozen for the whole access
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr <= '0;
         mem_din  <= '0;
         rd_data  <= '0;
      end else begin
         if (accept) begin
            mem_addr <= addr;
            mem_din  <= wr_data;
         end
         if (state_q == ST_RD_WAIT && mem_ready)
            rd_data <= mem_dout;
      end
   end

   // Moore strobe decode from the registered state only
   always_comb begin
      mem_ce  = 1'b0;
      mem_oe  = 1'b0;
      mem_we  = 1'b0;
      mem_drv = 1'b0;
      case (state_q)
         ST_RD0:                         mem_ce = 1'b1;
         ST_RD1, ST_RD2, ST_RD_WAIT: begin
            mem_ce = 1'b1;
            mem_oe = 1'b1;
         end
         ST_WR0, ST_WR1, ST_WR4, ST_WR_WAIT: begin
            mem_ce  = 1'b1;
            mem_drv = 1'b1;
         end
         ST_WR2, ST_WR3: begin
            mem_ce  = 1'b1;
            mem_drv = 1'b1;
            mem_we  = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = state_q;
   assign busy  = (state_q != ST_IDLE);

endmodule
